// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Edge feeder for the systolic array. Buffers one operand matrix (DEPTH vectors
// of LANES elements, DW bits each) and replays it diagonally skewed so that
// lane i trails lane 0 by i beats. Each lane drives the boundary register of
// one array row/column. Beats advance only on edges where out_en is high.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous, active-low reset
//   in_valid       - in_data holds a valid vector
//   in_ready       - feeder can accept a vector (LOAD state)
//   in_data        - input vector, lane i at [i*DW +: DW]
//   out_en         - array advance enable; outputs update only when high
//   out_data       - skewed element per lane, same packing as in_data
//   out_lane_valid - bit i high when out_data lane i carries a real element
//   busy           - high while streaming
//   done           - high while the final stream beat is on the outputs
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic                  out_en,
    output logic [LANES*DW-1:0]   out_data,
    output logic [LANES-1:0]      out_lane_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BEATS = DEPTH + LANES - 1;
    localparam int TW    = $clog2(BEATS + 1);

    localparam logic [AW-1:0] LAST_WR = AW'(DEPTH - 1);
    localparam logic [TW-1:0] LAST_T  = TW'(BEATS - 1);

    typedef enum logic {
        S_LOAD   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]          t_q, t_d;
    logic [LANES*DW-1:0]    mem_q [DEPTH];
    logic [LANES*DW-1:0]    mem_d [DEPTH];
    logic [LANES*DW-1:0]    out_data_q, out_data_d;
    logic [LANES-1:0]       out_lane_valid_q, out_lane_valid_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        t_d              = t_q;
        mem_d            = mem_q;
        out_data_d       = out_data_q;
        out_lane_valid_d = out_lane_valid_q;
        done_d           = done_q;

        case (state_q)
            S_LOAD: begin
                // in_ready is high for the whole LOAD state, so in_valid
                // alone completes the handshake.
                if (in_valid) begin
                    mem_d[wr_ptr_q] = in_data;
                    if (wr_ptr_q == LAST_WR) begin
                        wr_ptr_d = '0;
                        t_d      = '0;
                        state_d  = S_STREAM;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
                // A held final beat (and done) survives until the array
                // advances again; loading meanwhile does not touch it.
                if (out_en) begin
                    out_data_d       = '0;
                    out_lane_valid_d = '0;
                    done_d           = 1'b0;
                end
            end

            S_STREAM: begin
                if (out_en) begin
                    // Lane i shows element t-i when that index is in range;
                    // written as a compare-per-entry mux over the buffer.
                    out_data_d       = '0;
                    out_lane_valid_d = '0;
                    for (int i = 0; i < LANES; i++) begin
                        for (int d = 0; d < DEPTH; d++) begin
                            if (t_q == TW'(d + i)) begin
                                out_data_d[i*DW +: DW] = mem_q[d][i*DW +: DW];
                                out_lane_valid_d[i]    = 1'b1;
                            end
                        end
                    end
                    if (t_q == LAST_T) begin
                        t_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_LOAD;
            wr_ptr_q         <= '0;
            t_q              <= '0;
            out_data_q       <= '0;
            out_lane_valid_q <= '0;
            done_q           <= 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                mem_q[d] <= '0;
            end
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            t_q              <= t_d;
            out_data_q       <= out_data_d;
            out_lane_valid_q <= out_lane_valid_d;
            done_q           <= done_d;
            mem_q            <= mem_d;
        end
    end

    assign in_ready       = (state_q == S_LOAD);
    assign busy           = (state_q == S_STREAM);
    assign out_data       = out_data_q;
    assign out_lane_valid = out_lane_valid_q;
    assign done           = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Self-checking bench for systolic_skew_feeder (LANES=4, DEPTH=4, DW=8).
// Expected beats come from a matrix model: beat t, lane i carries element t-i
// when that index lies inside the matrix, otherwise zero.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int W     = LANES * DW;
    localparam int BEATS = DEPTH + LANES - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_en;
    logic [W-1:0]     out_data;
    logic [LANES-1:0] out_lane_valid;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]     mat [DEPTH];
    logic [W-1:0]     obs_data  [BEATS];
    logic [LANES-1:0] obs_valid [BEATS];
    logic             obs_done  [BEATS];
    logic             obs_busy  [BEATS];
    logic             obs_rdy   [BEATS];
    bit               load_to;

    systolic_skew_feeder #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_en         (out_en),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .busy           (busy),
        .done           (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] exp_data(int t);
        logic [W-1:0] r = '0;
        for (int i = 0; i < LANES; i++) begin
            int v = t - i;
            if (v >= 0 && v < DEPTH) r[i*DW +: DW] = mat[v][i*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [LANES-1:0] exp_valid(int t);
        logic [LANES-1:0] r = '0;
        for (int i = 0; i < LANES; i++) begin
            int v = t - i;
            r[i] = (v >= 0 && v < DEPTH);
        end
        return r;
    endfunction

    task automatic fill_pattern();
        for (int v = 0; v < DEPTH; v++)
            for (int i = 0; i < LANES; i++)
                mat[v][i*DW +: DW] = 8'(v * 16 + i);
    endtask

    task automatic fill_random();
        for (int v = 0; v < DEPTH; v++) mat[v] = W'($urandom);
    endtask

    // Push mat[first .. first+count-1] through the handshake. On timeout,
    // load_to is set and the calling scenario reports it.
    task automatic load_vecs(input int first, input int count, input bit toggle, input bit oe);
        int k = 0;
        int cyc = 0;
        bit acc;
        load_to = 1'b0;
        out_en  = oe;
        while (k < count) begin
            if (cyc >= count * 4 + 8) begin
                load_to = 1'b1;
                break;
            end
            if (toggle && cyc[0]) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = mat[first + k];
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    // Record n beats starting at beat index t0, advancing every edge.
    task automatic collect(input int t0, input int n);
        for (int k = 0; k < n; k++) begin
            out_en = 1'b1;
            tick();
            obs_data[t0+k]  = out_data;
            obs_valid[t0+k] = out_lane_valid;
            obs_done[t0+k]  = done;
            obs_busy[t0+k]  = busy;
            obs_rdy[t0+k]   = in_ready;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_en = 1'b0;
        #2 reset = 1'b0;
        #3;
        checks++;
        if (out_data !== '0 || out_lane_valid !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h vld=%b busy=%b done=%b expected all zero",
                     out_data, out_lane_valid, busy, done);
        end
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_basic_stream();
        int bc;
        logic [LANES-1:0] vtab [BEATS];
        vtab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        fill_pattern();
        load_vecs(0, DEPTH, 1'b0, 1'b1);
        checks++;
        if (load_to) begin failures++; $display("FAIL s1_load: timeout got no accept expected %0d", DEPTH); end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL s1_enter_stream: got rdy=%b busy=%b expected 0/1", in_ready, busy);
        end
        bc = busy ? 1 : 0;
        collect(0, BEATS);
        for (int t = 0; t < BEATS; t++) begin
            bc += obs_busy[t] ? 1 : 0;
            checks++;
            if (obs_data[t] !== exp_data(t)) begin
                failures++;
                $display("FAIL s1_data beat %0d: got %h expected %h", t, obs_data[t], exp_data(t));
            end
            checks++;
            if (obs_valid[t] !== vtab[t]) begin
                failures++;
                $display("FAIL s1_valid beat %0d: got %b expected %b", t, obs_valid[t], vtab[t]);
            end
            checks++;
            if (obs_done[t] !== (t == BEATS - 1)) begin
                failures++;
                $display("FAIL s1_done beat %0d: got %b expected %b", t, obs_done[t], t == BEATS - 1);
            end
        end
        checks++;
        if (obs_data[3] !== 32'h03122130 || obs_data[BEATS-1] !== 32'h33000000) begin
            failures++;
            $display("FAIL s1_const_beats: got %h/%h expected 03122130/33000000", obs_data[3], obs_data[BEATS-1]);
        end
        checks++;
        if (bc !== BEATS) begin
            failures++;
            $display("FAIL s1_busy_cycles: got %0d expected %0d", bc, BEATS);
        end
        out_en = 1'b1;
        tick();
        checks++;
        if (out_data !== '0 || out_lane_valid !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL s1_clear: got data=%h vld=%b done=%b expected zero", out_data, out_lane_valid, done);
        end
    endtask

    task automatic test_toggle_valid();
        fill_pattern();
        load_vecs(0, DEPTH, 1'b1, 1'b1);
        checks++;
        if (load_to) begin failures++; $display("FAIL s2_load: timeout got no accept expected %0d", DEPTH); end
        collect(0, BEATS);
        for (int t = 0; t < BEATS; t++) begin
            checks++;
            if (obs_data[t] !== exp_data(t) || obs_valid[t] !== exp_valid(t)) begin
                failures++;
                $display("FAIL s2_beat %0d: got %h/%b expected %h/%b", t, obs_data[t], obs_valid[t], exp_data(t), exp_valid(t));
            end
        end
        out_en = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        int bc;
        fill_pattern();
        load_vecs(0, DEPTH, 1'b0, 1'b1);
        checks++;
        if (load_to) begin failures++; $display("FAIL s3_load: timeout got no accept expected %0d", DEPTH); end
        bc = busy ? 1 : 0;
        collect(0, 4);
        out_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            bc += busy ? 1 : 0;
            checks++;
            if (out_data !== 32'h03122130 || out_lane_valid !== 4'b1111 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL s3_hold cycle %0d: got %h/%b busy=%b done=%b expected 03122130/1111 busy=1 done=0",
                         s, out_data, out_lane_valid, busy, done);
            end
        end
        collect(4, BEATS - 4);
        checks++;
        if (obs_data[4] !== 32'h13223100) begin
            failures++;
            $display("FAIL s3_resume: got %h expected 13223100", obs_data[4]);
        end
        for (int t = 0; t < BEATS; t++) begin
            bc += obs_busy[t] ? 1 : 0;
            checks++;
            if (obs_data[t] !== exp_data(t) || obs_done[t] !== (t == BEATS - 1)) begin
                failures++;
                $display("FAIL s3_beat %0d: got %h done=%b expected %h done=%b", t, obs_data[t], obs_done[t], exp_data(t), t == BEATS - 1);
            end
        end
        checks++;
        if (bc !== BEATS + 3) begin
            failures++;
            $display("FAIL s3_busy_cycles: got %0d expected %0d", bc, BEATS + 3);
        end
        out_en = 1'b1;
        tick();
    endtask

    task automatic test_valid_during_stream();
        fill_random();
        load_vecs(0, DEPTH, 1'b0, 1'b1);
        checks++;
        if (load_to) begin failures++; $display("FAIL s4_load: timeout got no accept expected %0d", DEPTH); end
        in_valid = 1'b1;
        in_data  = '1;
        collect(0, BEATS);
        for (int t = 0; t < BEATS; t++) begin
            checks++;
            if (obs_data[t] !== exp_data(t) || obs_valid[t] !== exp_valid(t)) begin
                failures++;
                $display("FAIL s4_beat %0d: got %h/%b expected %h/%b", t, obs_data[t], obs_valid[t], exp_data(t), exp_valid(t));
            end
            checks++;
            if (obs_rdy[t] !== (t == BEATS - 1)) begin
                failures++;
                $display("FAIL s4_ready beat %0d: got %b expected %b", t, obs_rdy[t], t == BEATS - 1);
            end
        end
        // in_valid still high: the next edge takes the first all-ones vector.
        tick();
        for (int v = 0; v < DEPTH; v++) mat[v] = '1;
        load_vecs(1, DEPTH - 1, 1'b0, 1'b1);
        checks++;
        if (load_to || busy !== 1'b1) begin
            failures++;
            $display("FAIL s4_ff_load: got timeout=%b busy=%b expected 0/1", load_to, busy);
        end
        collect(0, BEATS);
        for (int t = 0; t < BEATS; t++) begin
            checks++;
            if (obs_data[t] !== exp_data(t)) begin
                failures++;
                $display("FAIL s4_ff_beat %0d: got %h expected %h", t, obs_data[t], exp_data(t));
            end
        end
        out_en = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        fill_random();
        load_vecs(0, DEPTH, 1'b0, 1'b1);
        checks++;
        if (load_to) begin failures++; $display("FAIL s5_load: timeout got no accept expected %0d", DEPTH); end
        collect(0, 3);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_data !== '0 || out_lane_valid !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL s5_async_clear: got data=%h vld=%b busy=%b done=%b expected zero",
                     out_data, out_lane_valid, busy, done);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL s5_release: got rdy=%b busy=%b expected 1/0", in_ready, busy);
        end
        tick();
        fill_random();
        load_vecs(0, DEPTH, 1'b0, 1'b1);
        checks++;
        if (load_to) begin failures++; $display("FAIL s5_reload: timeout got no accept expected %0d", DEPTH); end
        collect(0, BEATS);
        for (int t = 0; t < BEATS; t++) begin
            checks++;
            if (obs_data[t] !== exp_data(t) || obs_valid[t] !== exp_valid(t)) begin
                failures++;
                $display("FAIL s5_beat %0d: got %h/%b expected %h/%b", t, obs_data[t], obs_valid[t], exp_data(t), exp_valid(t));
            end
        end
        out_en = 1'b1;
        tick();
    endtask

    task automatic test_held_done_overlap();
        fill_pattern();
        load_vecs(0, DEPTH, 1'b0, 1'b1);
        checks++;
        if (load_to) begin failures++; $display("FAIL s6_load: timeout got no accept expected %0d", DEPTH); end
        collect(0, BEATS);
        checks++;
        if (obs_done[BEATS-1] !== 1'b1 || obs_data[BEATS-1] !== 32'h33000000) begin
            failures++;
            $display("FAIL s6_final: got done=%b data=%h expected 1/33000000", obs_done[BEATS-1], obs_data[BEATS-1]);
        end
        fill_random();
        load_vecs(0, 2, 1'b0, 1'b0);
        checks++;
        if (load_to || done !== 1'b1 || out_data !== 32'h33000000 || out_lane_valid !== 4'b1000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL s6_hold: got to=%b done=%b data=%h vld=%b busy=%b expected 0/1/33000000/1000/0",
                     load_to, done, out_data, out_lane_valid, busy);
        end
        out_en = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || out_data !== '0 || out_lane_valid !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL s6_clear: got done=%b data=%h vld=%b rdy=%b expected 0/0/0/1",
                     done, out_data, out_lane_valid, in_ready);
        end
        load_vecs(2, 2, 1'b0, 1'b1);
        checks++;
        if (load_to || busy !== 1'b1) begin
            failures++;
            $display("FAIL s6_second_half: got to=%b busy=%b expected 0/1", load_to, busy);
        end
        collect(0, BEATS);
        for (int t = 0; t < BEATS; t++) begin
            checks++;
            if (obs_data[t] !== exp_data(t)) begin
                failures++;
                $display("FAIL s6_beat %0d: got %h expected %h", t, obs_data[t], exp_data(t));
            end
        end
        out_en = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_toggle_valid();
        test_stall();
        test_valid_during_stream();
        test_async_reset();
        test_held_done_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
